// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and address-width helper for the multi-port register file
package regfile_pkg;
   localparam int XLEN_DEF = 32;
   localparam int NREGS_DEF = 32;
   localparam int ZERO_REG = 0;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and scoreboard-set ports of the register file
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD = 2,
   parameter int NWR = 2,
   localparam int AW = clog2(NREGS)
);
   logic [NRD*AW-1:0] raddr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0] rbusy;
   logic [NWR-1:0] we;
   logic [NWR*AW-1:0] waddr;
   logic [NWR*XLEN-1:0] wdata;
   logic set_en;
   logic [AW-1:0] set_addr;
   modport master (output raddr, we, waddr, wdata, set_en, set_addr, input rdata, rbusy);
   modport slave (input raddr, we, waddr, wdata, set_en, set_addr, output rdata, rbusy);
endinterface

// File: rtl/rf_bypass_sel.sv
// rf_bypass_sel: per-read-port forwarding of same-cycle write data and busy masking
module rf_bypass_sel
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int AW = 5,
   parameter int NWR = 2,
   parameter int BYPASS = 1
) (
   input logic [AW-1:0] raddr,
   input logic [XLEN-1:0] rval,
   input logic busy,
   input logic [NWR-1:0] we,
   input logic [NWR*AW-1:0] waddr,
   input logic [NWR*XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata,
   output logic rbusy
);
   logic hit;
   logic [XLEN-1:0] fwd;
   // later ports overwrite earlier matches, so the highest index wins
   always_comb begin
      hit = 1'b0;
      fwd = rval;
      for (int j = 0; j < NWR; j++)
         if (we[j] && waddr[j*AW +: AW] == raddr && raddr != AW'(ZERO_REG)) begin
            hit = 1'b1;
            fwd = wdata[j*XLEN +: XLEN];
         end
      rdata = (BYPASS != 0) ? fwd : rval;
      rbusy = busy && !((BYPASS != 0) && hit);
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with hardwired x0, write bypass and busy scoreboard
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD = 2,
   parameter int NWR = 2,
   parameter int BYPASS = 1
) (
   input logic clk,
   input logic rst_n,
   regfile_mp_if.slave bus
);
   localparam int AW = clog2(NREGS);
   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] busy;
   // the set is applied after write clears so a new producer supersedes the retiring one
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regs <= '{default: '0};
         busy <= '0;
      end else begin
         for (int j = 0; j < NWR; j++)
            if (bus.we[j] && bus.waddr[j*AW +: AW] != AW'(ZERO_REG)) begin
               regs[bus.waddr[j*AW +: AW]] <= bus.wdata[j*XLEN +: XLEN];
               busy[bus.waddr[j*AW +: AW]] <= 1'b0;
            end
         if (bus.set_en && bus.set_addr != AW'(ZERO_REG)) busy[bus.set_addr] <= 1'b1;
      end
   end
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      rf_bypass_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR), .BYPASS(BYPASS)) u_sel (
         .raddr(bus.raddr[i*AW +: AW]),
         .rval(regs[bus.raddr[i*AW +: AW]]),
         .busy(busy[bus.raddr[i*AW +: AW]]),
         .we(bus.we),
         .waddr(bus.waddr),
         .wdata(bus.wdata),
         .rdata(bus.rdata[i*XLEN +: XLEN]),
         .rbusy(bus.rbusy[i])
      );
   end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the single-write/dual-read regfile.
- Adds configurable XLEN, depth and port counts, and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard for in-flight producers, and synchronous clear on reset.
- Sits in decode/writeback of the core: decode reads operands and busy flags, writeback drives write ports.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return array contents only.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- raddr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW].
- rdata  out  NRD*XLEN  read data; port i = bits [i*XLEN +: XLEN].
- rbusy  out  NRD  busy flag of the register addressed by each read port.
- we  in  NWR  per-port write enable.
- waddr  in  NWR*AW  write addresses.
- wdata  in  NWR*XLEN  write data.
- set_en  in  1  mark a register busy (producer issued).
- set_addr  in  AW  register to mark busy.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset: on a clk edge with rst_n=0, all registers and all busy bits clear to 0.
  - we and set_en are ignored in that cycle.
  - Reset mid-operation discards all in-flight writes and busy state.
- Reset output values: rdata and rbusy are combinational, so they are all 0 in the cycle after reset, whatever the addresses.
- Reads: combinational, zero latency. rdata[i] = reg[raddr[i]].
- Register 0 is hardwired:
  - rdata is always 0 for address 0.
  - rbusy is always 0 for address 0.
  - Writes and sets to address 0 are discarded.
- Writes: on a clk edge with rst_n=1 and we[j]=1 and waddr[j]!=0, reg[waddr[j]] <= wdata[j]. Data is visible in the array from the next cycle.
- Write conflict: if several enabled ports target the same address in one cycle, the highest-index port wins. The other data is dropped with no error.
- Bypass (BYPASS=1): if raddr[i] matches an enabled waddr[j] (non-zero) in the same cycle, rdata[i] = wdata[j].
  - Highest-index matching port wins, consistent with the write conflict rule.
  - With BYPASS=0, the old value is returned that cycle.
- Scoreboard: one busy bit per register.
  - Set: set_en=1 and set_addr!=0 sets busy[set_addr] at the clk edge.
  - Clear: any enabled write to address a clears busy[a] at the clk edge.
  - Simultaneous set and write to the same register: set wins, busy stays 1 (a new producer supersedes the retiring one).
  - Set of an already-busy register: stays 1, no counting.
- rbusy[i]:
  - BYPASS=1: rbusy[i] = busy[raddr[i]] AND NOT (same-cycle enabled write to raddr[i]). A consumer sees data ready as soon as writeback occurs.
  - BYPASS=0: rbusy[i] = busy[raddr[i]].
- Out-of-range addresses cannot occur, since NREGS is a power of two.
- No X propagation: all state is reset. Read addresses are don't-care only for unused ports.

Decomposition:
- Shared package regfile_pkg holds:
  - default constants XLEN_DEF=32, NREGS_DEF=32;
  - ZERO_REG=0;
  - the clog2 helper used to derive AW.
- Natural sub-module: rf_bypass_sel, one instance per read port.
  - Inputs: raddr, the array read value, we/waddr/wdata vectors, the busy bit.
  - Does the priority match across write ports and produces rdata[i] and rbusy[i].
  - Instantiated in a generate loop.

Test Plan:
- Reset then idle: rst_n=0 for 1 cycle, then raddr0=5, raddr1=31 -> rdata0=0, rdata1=0, rbusy=0.
- Basic write/read: we[0]=1, waddr0=1, wdata0=10; next cycle we[1]=1, waddr1=2, wdata1=20; then read raddr=1,2 -> rdata0=10, rdata1=20.
- x0 protection: we[0]=1, waddr0=0, wdata0=99; set_en=1, set_addr=0; read addr 0 -> rdata=0, rbusy=0 on the same cycle and the next.
- Bypass and conflict (BYPASS=1): both ports write addr 3, wdata0=0xAAAA, wdata1=0x5555, raddr0=3 in the same cycle.
  - Same cycle: rdata0=0x5555.
  - Next cycle: rdata0=0x5555.
  - With BYPASS=0 build: old value in the same cycle, 0x5555 the next.
- Scoreboard: set_en on addr 7 -> rbusy=1 next cycle on a read of 7.
  - Write addr 7 with 0x1234 -> rbusy=0 and rdata=0x1234 in the same cycle (BYPASS=1).
  - Then set_en and a write to addr 7 in the same cycle -> busy remains 1.
- Reset mid-operation: busy[4]=1 and reg[4]=0x77, assert rst_n=0 together with we on addr 4 -> next cycle reg[4]=0, busy[4]=0.
